// File: rtl/if_stage_pkg.sv
// Shared definitions for the fetch/decode boundary: bus widths, field
// offsets and the reset PC, so fetch and decode slice the buses identically.
package if_stage_pkg;

    localparam int FS_TO_DS_BUS_WD = 65;
    localparam int BR_BUS_WD       = 33;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    // fs_to_ds_bus = {adef, inst[31:0], pc[31:0]}
    localparam int FS_PC_LSB   = 0;
    localparam int FS_INST_LSB = 32;
    localparam int FS_ADEF_BIT = 64;

    // br_bus = {br_taken, br_target[31:0]}
    localparam int BR_TARGET_LSB = 0;
    localparam int BR_TAKEN_BIT  = 32;

    typedef struct packed {
        logic        adef;
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_to_ds_t;

    // Misaligned fetch address: decode turns this into an ADEF exception.
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives the synchronous
// instruction SRAM from the pre-IF nextpc, hands {adef, inst, pc} to decode
// over valid/allowin, squashes the wrong-path slot on a branch redirect and
// buffers the fetched word while decode stalls.
module if_stage #(
    parameter logic [31:0] RESET_PC = if_stage_pkg::RESET_PC
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   ds_allowin,
    input  logic [if_stage_pkg::BR_BUS_WD-1:0]     br_bus,
    output logic                                   fs_to_ds_valid,
    output logic [if_stage_pkg::FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                                   inst_sram_en,
    output logic                                   inst_sram_we,
    output logic [31:0]                            inst_sram_addr,
    output logic [31:0]                            inst_sram_wdata,
    input  logic [31:0]                            inst_sram_rdata
);
    import if_stage_pkg::*;

    logic        br_taken;
    logic [31:0] br_target;

    logic        to_fs_valid;
    logic [31:0] nextpc;

    logic        fs_valid;
    logic [31:0] fs_pc;
    logic        fs_ready_go;
    logic        fs_allowin;

    logic        inst_buf_valid;
    logic [31:0] inst_buf;
    logic [31:0] fs_inst;

    fs_to_ds_t   bus_s;

    assign br_taken  = br_bus[BR_TAKEN_BIT];
    assign br_target = br_bus[BR_TARGET_LSB +: 32];

    // Pre-IF: the redirect target bypasses the sequential PC so the target
    // is issued in the same cycle decode resolves the branch.
    assign to_fs_valid = ~reset;
    assign nextpc      = br_taken ? br_target : fs_pc + 32'd4;

    assign fs_ready_go = 1'b1;
    // A redirect always opens IF: the resident instruction is wrong-path.
    assign fs_allowin  = ~fs_valid | (ds_allowin & fs_ready_go) | br_taken;

    assign inst_sram_en    = to_fs_valid & fs_allowin;
    assign inst_sram_we    = 1'b0;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'd0;

    // IF register: advance whenever the stage can accept a new fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid <= 1'b0;
            fs_pc    <= RESET_PC - 32'd4;
        end else if (fs_allowin) begin
            fs_valid <= to_fs_valid;
            fs_pc    <= nextpc;
        end
    end

    // Instruction buffer: hold the SRAM word across a decode stall, since
    // the SRAM output is not guaranteed once its enable drops.
    always_ff @(posedge clk) begin
        if (reset || br_taken || (fs_to_ds_valid && ds_allowin)) begin
            inst_buf_valid <= 1'b0;
            inst_buf       <= 32'd0;
        end else if (fs_valid && !ds_allowin && !inst_buf_valid) begin
            inst_buf_valid <= 1'b1;
            inst_buf       <= inst_sram_rdata;
        end
    end

    assign fs_inst = inst_buf_valid ? inst_buf : inst_sram_rdata;

    assign fs_to_ds_valid = fs_valid & ~br_taken;

    assign bus_s.adef = pc_misaligned(fs_pc);
    assign bus_s.inst = fs_inst;
    assign bus_s.pc   = fs_pc;

    assign fs_to_ds_bus = bus_s;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random
// stall/redirect/reset traffic, compared against an architectural model
// that tracks "which PC sits in IF" and what word memory holds there.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ds_allowin;
    logic [32:0] br_bus;
    logic        fs_to_ds_valid;
    logic [64:0] fs_to_ds_bus;
    logic        inst_sram_en;
    logic        inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    int n_checks = 0;
    int n_errors = 0;

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .ds_allowin     (ds_allowin),
        .br_bus         (br_bus),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_we   (inst_sram_we),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata)
    );

    always #5 clk = ~clk;

    // Memory contents: an arbitrary but fixed word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9e37_79b1) ^ {a[15:0], a[31:16]} ^ 32'h0bad_f00d;
    endfunction

    // Synchronous SRAM: data is only trustworthy the cycle after an enabled
    // read; any other cycle returns junk so the buffer is really exercised.
    logic [31:0] sram_q;
    logic        sram_q_ok = 1'b0;
    logic [31:0] junk = 32'hdeadbeef;
    bit          junk_fixed = 1'b1;

    always @(posedge clk) begin
        if (inst_sram_en) begin
            sram_q    <= mem_word(inst_sram_addr);
            sram_q_ok <= 1'b1;
        end else begin
            sram_q_ok <= 1'b0;
        end
        junk <= junk_fixed ? 32'hdeadbeef : $urandom;
    end

    assign inst_sram_rdata = sram_q_ok ? sram_q : junk;

    // Decode's contract: br_taken never lasts more than one cycle.
    logic br_prev = 1'b0;
    always @(posedge clk) begin
        assert (!(br_prev && br_bus[32])) else $error("br_taken held two cycles");
        br_prev <= br_bus[32];
    end

    task automatic check_val(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural model: is there an instruction in IF, and at what PC.
    bit          m_valid = 1'b0;
    logic [31:0] m_pc    = RST_PC - 32'd4;
    int          n_handoffs = 0;

    // One clock: drive inputs, check outputs mid-cycle, advance the model.
    task automatic cycle(input bit rst, input bit dsa, input bit br, input logic [31:0] tgt);
        bit          e_en;
        logic [31:0] e_addr;
        bit          e_valid;
        reset      = rst;
        ds_allowin = dsa;
        br_bus     = {br, tgt};
        @(negedge clk);
        e_en    = !rst && (!m_valid || dsa || br);
        e_addr  = br ? tgt : m_pc + 32'd4;
        e_valid = m_valid && !br;
        check_val("sram_en", {64'd0, inst_sram_en}, {64'd0, e_en});
        if (!rst) check_val("sram_addr", {33'd0, inst_sram_addr}, {33'd0, e_addr});
        check_val("fs_valid", {64'd0, fs_to_ds_valid}, {64'd0, e_valid});
        if (e_valid)
            check_val("fs_bus", fs_to_ds_bus, {(m_pc[1:0] != 2'b00), mem_word(m_pc), m_pc});
        check_val("sram_we_wdata", {32'd0, inst_sram_we, inst_sram_wdata}, 65'd0);
        if (e_valid && dsa) n_handoffs++;
        if (rst) begin
            m_valid = 1'b0;
            m_pc    = RST_PC - 32'd4;
        end else if (e_en) begin
            m_valid = 1'b1;
            m_pc    = e_addr;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        ds_allowin = 1'b1;
        br_bus     = '0;
        @(posedge clk);
        #1;

        // Reset for 3 cycles, then release.
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 32'd0);
        cycle(0, 1, 0, 32'd0);                        // issues 1c000000
        cycle(0, 1, 0, 32'd0);                        // IF=1c000000
        check_val("first_pc", {33'd0, fs_to_ds_bus[31:0]}, {33'd0, 32'h1c00_0004});
        cycle(0, 1, 0, 32'd0);                        // IF=1c000004

        // Stall at 1c000008 for 3 cycles; SRAM output goes to junk.
        cycle(0, 0, 0, 32'd0);
        cycle(0, 0, 0, 32'd0);
        check_val("stall_inst", {33'd0, fs_to_ds_bus[63:32]}, {33'd0, mem_word(32'h1c00_0008)});
        check_val("stall_rdata_junk", {33'd0, inst_sram_rdata}, {33'd0, 32'hdeadbeef});
        cycle(0, 0, 0, 32'd0);
        check_val("post_stall_addr", {33'd0, inst_sram_addr}, {33'd0, 32'h1c00_000c});
        cycle(0, 1, 0, 32'd0);                        // release, issues 1c00000c

        // Redirect while IF holds 1c00000c.
        cycle(0, 1, 1, 32'h1c00_0100);
        check_val("redir_pc", {33'd0, fs_to_ds_bus[31:0]}, {33'd0, 32'h1c00_0100});
        check_val("redir_buf_clear", {64'd0, dut.inst_buf_valid}, 65'd0);
        cycle(0, 1, 0, 32'd0);

        // Redirect during a stall with the buffer full.
        cycle(0, 0, 0, 32'd0);
        cycle(0, 0, 0, 32'd0);
        check_val("buf_full", {64'd0, dut.inst_buf_valid}, 65'd1);
        cycle(0, 0, 1, 32'h1c00_0200);
        check_val("stall_redir_buf", {64'd0, dut.inst_buf_valid}, 65'd0);
        check_val("stall_redir_pc", {33'd0, fs_to_ds_bus[31:0]}, {33'd0, 32'h1c00_0200});
        cycle(0, 1, 0, 32'd0);

        // Misaligned target.
        cycle(0, 1, 1, 32'h1c00_0102);
        check_val("adef", {64'd0, fs_to_ds_bus[64]}, 65'd1);
        cycle(0, 1, 0, 32'd0);

        // Reset during a stall with the buffer full.
        cycle(0, 0, 0, 32'd0);
        cycle(0, 0, 0, 32'd0);
        cycle(1, 0, 0, 32'd0);
        check_val("rst_stall_buf", {64'd0, dut.inst_buf_valid}, 65'd0);
        cycle(0, 0, 0, 32'd0);
        cycle(0, 1, 0, 32'd0);
        cycle(0, 1, 0, 32'd0);

        // Random traffic.
        junk_fixed = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bit          r_rst;
            bit          r_dsa;
            bit          r_br;
            logic [31:0] r_tgt;
            r_rst = ($urandom_range(0, 99) == 0);
            r_dsa = ($urandom_range(0, 9) < 7);
            r_br  = !br_bus[32] && ($urandom_range(0, 5) == 0);
            r_tgt = $urandom;
            if ($urandom_range(0, 7) != 0) r_tgt[1:0] = 2'b00;
            cycle(r_rst, r_dsa, r_br, r_tgt);
        end
        check_val("handoffs_seen", {64'd0, (n_handoffs > 500)}, 65'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
